pipe_stage_skid: RTL and testbench



---
 rtl/pipe_stage_skid_pkg.sv | 16 +
 rtl/pipe_stage_skid_slot.sv | 19 +
 rtl/pipe_stage_skid.sv | 70 +++++++
 tb/tb_pipe_stage_skid.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/pipe_stage_skid_pkg.sv
// pipe_pkg: occupancy encodings and default constants shared by the skid pipeline stage.
package pipe_pkg;
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;
  localparam logic [31:0] PC_RESET_DEFAULT  = 32'h0000_3000;
  localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0000;
  localparam int XLEN_DEFAULT    = 32;
  localparam int EXTRA_W_DEFAULT = 64;
  localparam int PAYLOAD_W       = 2 * XLEN_DEFAULT + EXTRA_W_DEFAULT;
  function automatic int payload_w(input int xlen, input int extra_w);
    return 2 * xlen + extra_w;
  endfunction
endpackage

// File: rtl/pipe_stage_skid_slot.sv
// pipe_slot: one payload register; clear returns it to the bubble value and wins over load.
module pipe_slot
  import pipe_pkg::*;
#(
  parameter int             W      = PAYLOAD_W,
  parameter logic [W-1:0]   BUBBLE = '0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr_i,
  input  logic         ld_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);
  logic [W-1:0] q_q, q_d;
  always_comb q_d = clr_i ? BUBBLE : ld_i ? d_i : q_q;
  always_ff @(posedge clk) q_q <= reset ? BUBBLE : q_d;
  assign q_o = q_q;
endmodule

// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid: valid/ready pipeline register with 2-entry skid, flush and occupancy.
// Perf counters stall_cnt/bubble_cnt exist only when PIPE_STAGE_PERF_CNT_EN is defined.
module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int                XLEN      = XLEN_DEFAULT,
  parameter int                EXTRA_W   = EXTRA_W_DEFAULT,
  parameter logic [XLEN-1:0]   PC_RESET  = XLEN'(PC_RESET_DEFAULT),
  parameter logic [XLEN-1:0]   NOP_INSTR = XLEN'(NOP_INSTR_DEFAULT)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [XLEN-1:0]    in_instr,
  input  logic [XLEN-1:0]    in_pc4,
  input  logic [EXTRA_W-1:0] in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [XLEN-1:0]    out_instr,
  output logic [XLEN-1:0]    out_pc4,
  output logic [EXTRA_W-1:0] out_data,
  output logic [1:0]         occupancy,
  output logic [31:0]        stall_cnt,
  output logic [31:0]        bubble_cnt
);
  localparam int PW = payload_w(XLEN, EXTRA_W);
  localparam logic [PW-1:0] BUBBLE = {NOP_INSTR, PC_RESET, {EXTRA_W{1'b0}}};
  state_t occ_q, occ_d;
  logic [PW-1:0] main_q, skid_q, main_d;
  logic in_fire, out_fire, main_ld, main_clr, skid_ld, skid_clr;
  assign in_ready  = occ_q != ST_FULL;
  assign out_valid = occ_q != ST_EMPTY;
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;
  // FULL refills main from skid; otherwise main only ever takes the upstream entry
  assign main_d   = (occ_q == ST_FULL) ? skid_q : {in_instr, in_pc4, in_data};
  assign main_ld  = (occ_q == ST_EMPTY & in_fire) | (occ_q == ST_ONE & in_fire & out_fire) |
                    (occ_q == ST_FULL & out_fire);
  assign main_clr = flush | (occ_q == ST_ONE & !in_fire & out_fire);
  assign skid_ld  = occ_q == ST_ONE & in_fire & !out_ready;
  assign skid_clr = flush | (occ_q == ST_FULL & out_fire);
  always_comb
    occ_d = flush ? ST_EMPTY :
            (in_fire & !out_fire) ? state_t'(occ_q + 2'd1) :
            (!in_fire & out_fire) ? state_t'(occ_q - 2'd1) : occ_q;
  always_ff @(posedge clk) occ_q <= reset ? ST_EMPTY : occ_d;
  pipe_slot #(.W(PW), .BUBBLE(BUBBLE)) u_main (
    .clk(clk), .reset(reset), .clr_i(main_clr), .ld_i(main_ld), .d_i(main_d), .q_o(main_q)
  );
  pipe_slot #(.W(PW), .BUBBLE(BUBBLE)) u_skid (
    .clk(clk), .reset(reset), .clr_i(skid_clr), .ld_i(skid_ld),
    .d_i({in_instr, in_pc4, in_data}), .q_o(skid_q)
  );
  assign {out_instr, out_pc4, out_data} = main_q;
  assign occupancy = occ_q;
`ifdef PIPE_STAGE_PERF_CNT_EN
  logic [31:0] stall_q, bubble_q;
  always_ff @(posedge clk) begin
    stall_q  <= reset ? 32'd0 : stall_q + {31'd0, out_valid & !out_ready};
    bubble_q <= reset ? 32'd0 : bubble_q + {31'd0, !out_valid & !flush};
  end
  assign stall_cnt  = stall_q;
  assign bubble_cnt = bubble_q;
`else
  assign stall_cnt  = 32'd0;
  assign bubble_cnt = 32'd0;
`endif
endmodule

// File: tb/tb_pipe_stage_skid.sv
// tb_pipe_stage_skid: directed plus random stimulus against a FIFO-queue reference model.
module tb_pipe_stage_skid;
  typedef struct packed {
    logic [31:0] i;
    logic [31:0] p;
    logic [63:0] d;
  } ent_t;
  localparam ent_t BUB = '{i: 32'h0, p: 32'h3000, d: 64'h0};

  logic clk = 1'b0;
  logic reset = 1'b1, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [31:0] in_instr = '0, in_pc4 = '0;
  logic [63:0] in_data = '0;
  logic in_ready, out_valid;
  logic [31:0] out_instr, out_pc4, stall_cnt, bubble_cnt;
  logic [63:0] out_data;
  logic [1:0] occupancy;

  int checks = 0, errors = 0;
  ent_t q[$];
  logic [31:0] m_stall = '0, m_bubble = '0;

  pipe_stage_skid dut (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc4(in_pc4), .in_data(in_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_instr(out_instr), .out_pc4(out_pc4), .out_data(out_data),
    .occupancy(occupancy), .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_model();
    ent_t e;
    e = (q.size() > 0) ? q[0] : BUB;
    chk("out_valid", out_valid, q.size() > 0);
    chk("in_ready", in_ready, q.size() < 2);
    chk("occupancy", occupancy, q.size());
    chk("out_instr", out_instr, e.i);
    chk("out_pc4", out_pc4, e.p);
    chk("out_data", out_data, e.d);
`ifdef PIPE_STAGE_PERF_CNT_EN
    chk("stall_cnt", stall_cnt, m_stall);
    chk("bubble_cnt", bubble_cnt, m_bubble);
`else
    chk("stall_cnt", stall_cnt, 0);
    chk("bubble_cnt", bubble_cnt, 0);
`endif
  endtask

  // one clock: drive at negedge, advance the queue model at posedge, check at next negedge
  task automatic cycle(input logic rst, input logic fl, input logic iv, input logic ordy, input ent_t e);
    bit m_ov, m_ir;
    reset = rst; flush = fl; in_valid = iv; out_ready = ordy;
    in_instr = e.i; in_pc4 = e.p; in_data = e.d;
    m_ov = q.size() > 0;
    m_ir = q.size() < 2;
    @(posedge clk);
    if (rst) begin
      q.delete();
      m_stall = '0;
      m_bubble = '0;
    end else begin
      if (m_ov && !ordy) m_stall++;
      if (!m_ov && !fl) m_bubble++;
      if (fl) q.delete();
      else begin
        if (m_ov && ordy) void'(q.pop_front());
        if (iv && m_ir) q.push_back(e);
      end
    end
    @(negedge clk);
    check_model();
  endtask

  function automatic ent_t mk(input logic [31:0] i);
    return '{i: i, p: i ^ 32'h0001_0000, d: {i, ~i}};
  endfunction

  function automatic ent_t rnd();
    return '{i: $urandom, p: $urandom, d: {$urandom, $urandom}};
  endfunction

  initial begin
    @(negedge clk);
    cycle(1, 0, 0, 0, BUB);
    cycle(1, 0, 1, 1, rnd());
    chk("rst_valid", out_valid, 0);
    chk("rst_pc4", out_pc4, 32'h3000);
    chk("rst_instr", out_instr, 0);
    chk("rst_ready", in_ready, 1);
    chk("rst_occ", occupancy, 0);
    // streaming: each entry visible one cycle after acceptance
    for (int k = 0; k < 4; k++) begin
      cycle(0, 0, 1, 1, mk(32'h8C01_0004 + 32'(4 * k)));
      chk("stream_instr", out_instr, 32'h8C01_0004 + 32'(4 * k));
      chk("stream_occ", occupancy, 1);
    end
    cycle(0, 0, 0, 1, BUB);
    // backpressure: A main, B skid, C refused
    cycle(0, 0, 1, 0, mk(32'hA));
    cycle(0, 0, 1, 0, mk(32'hB));
    cycle(0, 0, 1, 0, mk(32'hC));
    chk("bp_occ", occupancy, 2);
    chk("bp_ready", in_ready, 0);
    chk("bp_main", out_instr, 32'hA);
    cycle(0, 0, 1, 1, mk(32'hC));
    chk("rel_b", out_instr, 32'hB);
    cycle(0, 0, 1, 1, mk(32'hC));
    chk("rel_c", out_instr, 32'hC);
    cycle(0, 0, 0, 1, BUB);
    chk("rel_empty", occupancy, 0);
    // flush while full with a concurrent offer of D
    cycle(0, 0, 1, 0, mk(32'hA2));
    cycle(0, 0, 1, 0, mk(32'hB2));
    cycle(0, 1, 1, 0, mk(32'hD));
    chk("fl_occ", occupancy, 0);
    chk("fl_pc4", out_pc4, 32'h3000);
    chk("fl_instr", out_instr, 0);
    cycle(0, 0, 0, 1, BUB);
    cycle(0, 0, 0, 1, BUB);
    // reset mid-stall
    cycle(0, 0, 1, 0, mk(32'hA3));
    cycle(0, 0, 1, 0, mk(32'hB3));
    cycle(1, 0, 1, 0, mk(32'hF));
    chk("rs_occ", occupancy, 0);
    chk("rs_pc4", out_pc4, 32'h3000);
    chk("rs_ready", in_ready, 1);
    cycle(0, 0, 1, 1, mk(32'hE));
    chk("rs_e", out_instr, 32'hE);
    chk("rs_e_valid", out_valid, 1);
    // perf: one load cycle (a bubble), 5 stalls, drain, 3 empty cycles
    cycle(1, 0, 0, 0, BUB);
    cycle(0, 0, 1, 0, mk(32'h77));
    for (int k = 0; k < 5; k++) cycle(0, 0, 0, 0, BUB);
`ifdef PIPE_STAGE_PERF_CNT_EN
    chk("perf_stall5", stall_cnt, 5);
    chk("perf_bub_pre", bubble_cnt, 1);
`else
    chk("perf_stall0", stall_cnt, 0);
`endif
    cycle(0, 0, 0, 1, BUB);
    for (int k = 0; k < 3; k++) cycle(0, 0, 0, 1, BUB);
`ifdef PIPE_STAGE_PERF_CNT_EN
    chk("perf_stall_hold", stall_cnt, 5);
    chk("perf_bub3", bubble_cnt, 4);
`else
    chk("perf_bub0", bubble_cnt, 0);
`endif
    // random traffic with occasional flush and reset
    for (int k = 0; k < 500; k++)
      cycle($urandom_range(63) == 0, $urandom_range(15) == 0, 1'($urandom), $urandom_range(3) != 0, rnd());
    for (int k = 0; k < 3; k++) cycle(0, 0, 0, 1, BUB);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
